// File: rtl/prog_rom_banked.sv
// Banked instruction store: registered fetch with a valid/ready handshake, runtime bank select and a load port.
// Optional feature macro: PROG_ROM_PARITY_EN adds a stored even-parity bit per word, checked on fetch.
module prog_rom_banked #(
   parameter int A      = 4,
   parameter int W_INST = 28,
   parameter int BANKS  = 2,
   parameter int BW     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic              refresh_clk,
   input  logic              rst_n_i,
   input  logic              fvalid_i,
   output logic              fready_o,
   input  logic [A-1:0]      addr_i,
   output logic [W_INST-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic              bank_wr_i,
   input  logic [BW-1:0]     bank_i,
   output logic [BW-1:0]     bank_o,
   input  logic              ld_en_i,
   input  logic [BW-1:0]     ld_bank_i,
   input  logic [A-1:0]      ld_addr_i,
   input  logic [W_INST-1:0] ld_data_i,
   output logic              err_o
);

   localparam int DEPTH = 2**A;

   logic [W_INST-1:0] mem_q [BANKS][DEPTH];
   logic [W_INST-1:0] mem_d [BANKS][DEPTH];
`ifdef PROG_ROM_PARITY_EN
   logic              par_q [BANKS][DEPTH];
   logic              par_d [BANKS][DEPTH];
`endif
   logic [BW-1:0]     bank_q, bank_d;
   logic [W_INST-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic              accept_s;
   logic              ld_ok_s;
   logic              bank_ok_s;
   logic              hit_s;
   logic [W_INST-1:0] rd_word_s;
   logic              rd_err_s;

   function automatic logic [W_INST-1:0] rom_init(input int b, input int a);
      logic [27:0] w;
      w = 28'h0;
      if (b == 0) begin
         case (a)
            0:       w = 28'h14014EC;
            1:       w = 28'h3904060;
            2:       w = 28'h39560C0;
            3:       w = 28'h0840100;
            default: w = 28'h0;
         endcase
      end else if (b == 1) begin
         case (a)
            0:       w = 28'h640050C;
            1:       w = 28'hC009060;
            2:       w = 28'hC094090;
            3:       w = 28'h0840100;
            default: w = 28'h0;
         endcase
      end else begin
         w = 28'h0;
      end
      return W_INST'(w);
   endfunction

   function automatic logic even_par(input logic [W_INST-1:0] w);
      return ^w;
   endfunction

   assign fready_o = !valid_q | ready_i;
   assign data_o   = data_q;
   assign valid_o  = valid_q;
   assign bank_o   = bank_q;
   assign err_o    = err_q;

   // Handshake qualification, range guards and the write-first bypass select.
   always_comb begin
      accept_s  = fvalid_i & fready_o;
      ld_ok_s   = ld_en_i & (int'(ld_bank_i) < BANKS);
      bank_ok_s = bank_wr_i & (int'(bank_i) < BANKS);
      hit_s     = ld_ok_s & (ld_bank_i == bank_q) & (ld_addr_i == addr_i);
      rd_word_s = mem_q[bank_q][addr_i];
      rd_err_s  = 1'b0;
      if (hit_s) begin
         rd_word_s = ld_data_i;
      end else begin
         rd_word_s = mem_q[bank_q][addr_i];
      end
`ifdef PROG_ROM_PARITY_EN
      // A bypassed word carries freshly computed parity, so it can never flag.
      if (hit_s) begin
         rd_err_s = 1'b0;
      end else begin
         rd_err_s = even_par(rd_word_s) ^ par_q[bank_q][addr_i];
      end
`endif
   end

   // Next state for storage, bank select and the one-entry output register.
   always_comb begin
      mem_d   = mem_q;
`ifdef PROG_ROM_PARITY_EN
      par_d   = par_q;
`endif
      bank_d  = bank_q;
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (ld_ok_s) begin
         mem_d[ld_bank_i][ld_addr_i] = ld_data_i;
`ifdef PROG_ROM_PARITY_EN
         par_d[ld_bank_i][ld_addr_i] = even_par(ld_data_i);
`endif
      end else begin
         mem_d = mem_q;
      end
      if (bank_ok_s) begin
         bank_d = bank_i;
      end else begin
         bank_d = bank_q;
      end
      if (accept_s) begin
         valid_d = 1'b1;
         data_d  = rd_word_s;
         err_d   = rd_err_s;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers; reset reloads the default program image.
   always_ff @(posedge refresh_clk) begin
      if (!rst_n_i) begin
         for (int b = 0; b < BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
               mem_q[b][a] <= rom_init(b, a);
`ifdef PROG_ROM_PARITY_EN
               par_q[b][a] <= even_par(rom_init(b, a));
`endif
            end
         end
         bank_q  <= {BW{1'b0}};
         data_q  <= {W_INST{1'b0}};
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
`ifdef PROG_ROM_PARITY_EN
         par_q   <= par_d;
`endif
         bank_q  <= bank_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_rom_banked.sv
// Directed bench for prog_rom_banked: vector table plus hand-written stall, reset and bank-range sequences.
module tb_prog_rom_banked;

   logic        refresh_clk;
   logic        rst_n_i;
   logic        fvalid_i;
   logic        fready_o;
   logic [3:0]  addr_i;
   logic [27:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        bank_wr_i;
   logic        bank_i;
   logic        bank_o;
   logic        ld_en_i;
   logic        ld_bank_i;
   logic [3:0]  ld_addr_i;
   logic [27:0] ld_data_i;
   logic        err_o;

   logic        fready3;
   logic [27:0] data3;
   logic        valid3;
   logic        bwr3;
   logic [1:0]  bank3_i;
   logic [1:0]  bank3_o;
   logic        ld3;
   logic [1:0]  ld_bank3;
   logic        err3;

   int ncmp;
   int nerr;

   prog_rom_banked dut (
      .refresh_clk(refresh_clk), .rst_n_i(rst_n_i), .fvalid_i(fvalid_i), .fready_o(fready_o),
      .addr_i(addr_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .bank_wr_i(bank_wr_i), .bank_i(bank_i), .bank_o(bank_o), .ld_en_i(ld_en_i),
      .ld_bank_i(ld_bank_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .err_o(err_o)
   );

   prog_rom_banked #(.BANKS(3)) dut3 (
      .refresh_clk(refresh_clk), .rst_n_i(rst_n_i), .fvalid_i(fvalid_i), .fready_o(fready3),
      .addr_i(addr_i), .data_o(data3), .valid_o(valid3), .ready_i(ready_i),
      .bank_wr_i(bwr3), .bank_i(bank3_i), .bank_o(bank3_o), .ld_en_i(ld3),
      .ld_bank_i(ld_bank3), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .err_o(err3)
   );

   initial refresh_clk = 1'b0;
   always #5 refresh_clk = ~refresh_clk;

   typedef struct {
      logic        fv;
      logic [3:0]  addr;
      logic        rdy;
      logic        bwr;
      logic        bk;
      logic        ld;
      logic        lbk;
      logic [3:0]  la;
      logic [27:0] ldd;
      logic        ev;
      logic [27:0] ed;
      logic        eb;
      logic        ef;
   } vec_t;

   vec_t tbl [18];

   task automatic tick();
      @(posedge refresh_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      fvalid_i = 1'b0; addr_i = 4'h0; ready_i = 1'b1; bank_wr_i = 1'b0; bank_i = 1'b0;
      ld_en_i = 1'b0; ld_bank_i = 1'b0; ld_addr_i = 4'h0; ld_data_i = 28'h0;
      bwr3 = 1'b0; bank3_i = 2'd0; ld3 = 1'b0; ld_bank3 = 2'd0;
   endtask

   initial begin
      ncmp = 0;
      nerr = 0;
      //          fv    addr   rdy   bwr   bk    ld    lbk   la     ldd          ev    ed           eb    ef
      tbl[0]  = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h14014EC, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h3904060, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h39560C0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h0840100, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 4'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h3904060, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'hC009060, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b0, 28'hC009060, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b0, 28'hC009060, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  28'hABCDEF1, 1'b1, 28'hABCDEF1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'hABCDEF1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  28'h1234567, 1'b1, 28'h14014EC, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h14014EC, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h1234567, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  28'h7654321, 1'b1, 28'h1234567, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b0, 28'h1234567, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h7654321, 1'b1, 1'b1};
      tbl[16] = '{1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h0,       1'b0, 1'b1};
      tbl[17] = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  28'h0,       1'b1, 28'h39560C0, 1'b0, 1'b1};

      idle();
      rst_n_i = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_data",  32'(data_o),  32'h0);
      chk("rst_bank",  32'(bank_o),  32'h0);
      chk("rst_err",   32'(err_o),   32'h0);
      chk("rst_fready", 32'(fready_o), 32'h1);
      rst_n_i = 1'b1;

      for (int i = 0; i < 18; i++) begin
         fvalid_i = tbl[i].fv;  addr_i = tbl[i].addr; ready_i = tbl[i].rdy;
         bank_wr_i = tbl[i].bwr; bank_i = tbl[i].bk;  ld_en_i = tbl[i].ld;
         ld_bank_i = tbl[i].lbk; ld_addr_i = tbl[i].la; ld_data_i = tbl[i].ldd;
         tick();
         chk($sformatf("v%0d_valid", i),  32'(valid_o),  32'(tbl[i].ev));
         chk($sformatf("v%0d_data", i),   32'(data_o),   32'(tbl[i].ed));
         chk($sformatf("v%0d_bank", i),   32'(bank_o),   32'(tbl[i].eb));
         chk($sformatf("v%0d_fready", i), 32'(fready_o), 32'(tbl[i].ef));
         chk($sformatf("v%0d_err", i),    32'(err_o),    32'h0);
      end

      // Stall three cycles with a pending request, then release once.
      idle();
      fvalid_i = 1'b1; addr_i = 4'd3; ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stall%0d_data", k),   32'(data_o),   32'h39560C0);
         chk($sformatf("stall%0d_valid", k),  32'(valid_o),  32'h1);
         chk($sformatf("stall%0d_fready", k), 32'(fready_o), 32'h0);
      end
      fvalid_i = 1'b0; ready_i = 1'b1;
      tick();
      chk("release_valid", 32'(valid_o), 32'h0);
      chk("release_data",  32'(data_o),  32'h39560C0);

      // Reset while a word is stalled in the output register.
      idle();
      bank_wr_i = 1'b1; bank_i = 1'b1;
      tick();
      idle();
      fvalid_i = 1'b1; addr_i = 4'd2; ready_i = 1'b0;
      tick();
      chk("pre_rst_data", 32'(data_o), 32'hC094090);
      fvalid_i = 1'b0;
      tick();
      rst_n_i = 1'b0;
      tick();
      chk("midrst_valid",  32'(valid_o),  32'h0);
      chk("midrst_data",   32'(data_o),   32'h0);
      chk("midrst_bank",   32'(bank_o),   32'h0);
      chk("midrst_fready", 32'(fready_o), 32'h1);
      rst_n_i = 1'b1;
      idle();
      fvalid_i = 1'b1; addr_i = 4'd5;
      tick();
      chk("reload_b0a5", 32'(data_o), 32'h0);
      addr_i = 4'd0;
      tick();
      chk("reload_b0a0", 32'(data_o), 32'h14014EC);
      bank_wr_i = 1'b1; bank_i = 1'b1;
      tick();
      chk("oldbank_b0a0", 32'(data_o), 32'h14014EC);
      bank_wr_i = 1'b0;
      tick();
      chk("reload_b1a0", 32'(data_o), 32'h640050C);

      // Out-of-range bank select and load, on a three-bank instance.
      idle();
      bwr3 = 1'b1; bank3_i = 2'd3;
      tick();
      chk("b3_sel3_ignored", 32'(bank3_o), 32'h0);
      bank3_i = 2'd2;
      tick();
      chk("b3_sel2", 32'(bank3_o), 32'h2);
      bwr3 = 1'b0;
      ld3 = 1'b1; ld_bank3 = 2'd3; ld_addr_i = 4'd0; ld_data_i = 28'hFFFFFFF;
      fvalid_i = 1'b1; addr_i = 4'd0;
      tick();
      chk("b3_bank2_a0", 32'(data3), 32'h0);
      ld3 = 1'b0;
      bwr3 = 1'b1; bank3_i = 2'd0;
      tick();
      chk("b3_oldbank", 32'(data3), 32'h0);
      bwr3 = 1'b0;
      tick();
      chk("b3_b0a0", 32'(data3), 32'h14014EC);
      chk("b3_bank0", 32'(bank3_o), 32'h0);
      chk("b3_err", 32'(err3), 32'h0);
      chk("b3_fready", 32'(fready3), 32'h1);
      chk("b3_valid", 32'(valid3), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
